// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Decode stage that sits directly after fetch. It holds the IF/ID
//   instruction register, decodes the 16-bit instruction word and drives the
//   fetch-side controls. It sequences the multi-cycle cases: two-word
//   (immediate) instructions, JMP/CALL redirects and RET/RTI return-address
//   pops. The decoded fields are registered into the ID/EX outputs.
//
// Ports
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_if_instr           instruction word from fetch (NOP while fetch is flushed)
//   i_if_imm             raw memory word at the current fetch pc
//   i_if_pc_1            pc+1 from fetch
//   i_branch             taken branch resolved in execute
//   i_hold               load-use stall from the hazard unit
//   i_pop_valid          one popped return-address word is on the fetch WD bus
//   o_pc_enb             fetch pc write enable             (combinational)
//   o_flush              fetch instruction squash          (combinational)
//   o_jump_sel           00 pc+1, 01 Rdst_D, 10 ISR, 11 popped address
//   o_pop_l_h            00 idle, 11 write high word, 10 write low word
//   o_ex_*               registered ID/EX fields; all zero when not issuing
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int W   = 16,
    parameter int PCW = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [W-1:0]   i_if_instr,
    input  logic [W-1:0]   i_if_imm,
    input  logic [PCW-1:0] i_if_pc_1,
    input  logic           i_branch,
    input  logic           i_hold,
    input  logic           i_pop_valid,
    output logic           o_pc_enb,
    output logic           o_flush,
    output logic [1:0]     o_jump_sel,
    output logic [1:0]     o_pop_l_h,
    output logic           o_ex_valid,
    output logic [5:0]     o_ex_opcode,
    output logic [2:0]     o_ex_src,
    output logic [2:0]     o_ex_dst,
    output logic [3:0]     o_ex_shamt,
    output logic [W-1:0]   o_ex_imm,
    output logic [PCW-1:0] o_ex_pc_1
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_H  = 2'd1,
        WAIT_L  = 2'd2,
        RET_JMP = 2'd3
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_JMP  = 6'b100000;
    localparam logic [5:0] OP_CALL = 6'b100001;
    localparam logic [5:0] OP_RET  = 6'b100010;
    localparam logic [5:0] OP_RTI  = 6'b100011;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_ir;
    logic [PCW-1:0] r_ir_pc_1;

    logic [5:0]     w_op;
    logic           w_is_nop;
    logic           w_is_two;
    logic           w_is_jmp;
    logic           w_is_ret;
    logic           w_issue;
    logic           w_ir_load;

    assign w_op     = r_ir[15:10];
    assign w_is_nop = (w_op == OP_NOP);
    assign w_is_two = (w_op[5:4] == 2'b11);
    assign w_is_jmp = (w_op == OP_JMP) || (w_op == OP_CALL);
    assign w_is_ret = (w_op == OP_RET) || (w_op == OP_RTI);

    // Fetch-side control and next state. Branch squashes whatever sits in ir,
    // including RET/CALL/two-word, so it is checked before anything else.
    always_comb begin
        o_pc_enb    = 1'b1;
        o_flush     = 1'b0;
        o_jump_sel  = 2'b00;
        o_pop_l_h   = 2'b00;
        w_issue     = 1'b0;
        w_ir_load   = 1'b1;
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (i_branch) begin
                    o_flush = 1'b1;
                end else if (i_hold) begin
                    o_pc_enb  = 1'b0;
                    w_ir_load = 1'b0;
                end else if (!w_is_nop) begin
                    w_issue = 1'b1;
                    if (w_is_two) begin
                        // the immediate word is in fetch now; keep it out of ir
                        o_flush = 1'b1;
                    end else if (w_is_jmp) begin
                        o_jump_sel = 2'b01;
                        o_flush    = 1'b1;
                    end else if (w_is_ret) begin
                        o_flush     = 1'b1;
                        o_pc_enb    = 1'b0;
                        w_state_nxt = WAIT_H;
                    end
                end
            end
            WAIT_H: begin
                o_pc_enb = 1'b0;
                o_flush  = 1'b1;
                if (i_pop_valid) begin
                    o_pop_l_h   = 2'b11;
                    w_state_nxt = WAIT_L;
                end
            end
            WAIT_L: begin
                o_pc_enb = 1'b0;
                o_flush  = 1'b1;
                if (i_pop_valid) begin
                    o_pop_l_h   = 2'b10;
                    w_state_nxt = RET_JMP;
                end
            end
            default: begin // RET_JMP
                o_jump_sel  = 2'b11;
                o_flush     = 1'b1;
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RUN;
            r_ir      <= '0;
            r_ir_pc_1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ir_load) begin
                r_ir      <= i_if_instr;
                r_ir_pc_1 <= i_if_pc_1;
            end
        end
    end

    // ID/EX register: fields of ir when issuing, all zero otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ex_valid  <= 1'b0;
            o_ex_opcode <= '0;
            o_ex_src    <= '0;
            o_ex_dst    <= '0;
            o_ex_shamt  <= '0;
            o_ex_imm    <= '0;
            o_ex_pc_1   <= '0;
        end else if (w_issue) begin
            o_ex_valid  <= 1'b1;
            o_ex_opcode <= w_op;
            o_ex_src    <= r_ir[9:7];
            o_ex_dst    <= r_ir[6:4];
            o_ex_shamt  <= r_ir[3:0];
            o_ex_imm    <= w_is_two ? i_if_imm : '0;
            o_ex_pc_1   <= r_ir_pc_1;
        end else begin
            o_ex_valid  <= 1'b0;
            o_ex_opcode <= '0;
            o_ex_src    <= '0;
            o_ex_dst    <= '0;
            o_ex_shamt  <= '0;
            o_ex_imm    <= '0;
            o_ex_pc_1   <= '0;
        end
    end

endmodule
